// File: rtl/nios2_debug_slave_sysclk_gen2_if.sv
// Debug-slave bus: the TCK-domain strobes and data coming in, and the
// captured command going out to the core.
interface nios2_debug_slave_sysclk_gen2_if #(
  parameter int unsigned DATA_W = 38,
  parameter int unsigned IR_W   = 2,
  parameter int unsigned CNT_W  = 8
) ();
  localparam int unsigned NI = 2 ** IR_W;

  logic              vs_uir;
  logic              vs_udr;
  logic [IR_W-1:0]   ir_in;
  logic [DATA_W-1:0] sr;
  logic              act_ack;
  logic              ovr_clr;
  logic [DATA_W-1:0] jdo;
  logic [IR_W-1:0]   ir_q;
  logic [NI-1:0]     take_action;
  logic [NI-1:0]     take_no_action;
  logic              cmd_pending;
  logic              overrun;
  logic [CNT_W-1:0]  cmd_count;

  modport slave (
    input  vs_uir, vs_udr, ir_in, sr, act_ack, ovr_clr,
    output jdo, ir_q, take_action, take_no_action, cmd_pending, overrun, cmd_count
  );

  modport master (
    output vs_uir, vs_udr, ir_in, sr, act_ack, ovr_clr,
    input  jdo, ir_q, take_action, take_no_action, cmd_pending, overrun, cmd_count
  );
endinterface

// File: rtl/nios2_debug_slave_sysclk_gen2.sv
// System-clock half of the Nios II JTAG debug slave: synchronises the TCK-domain
// update strobes, captures jdo and raises per-instruction action/no-action strobes.
module nios2_debug_slave_sysclk_gen2 #(
  parameter int unsigned DATA_W      = 38,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACT_BIT     = 36,
  parameter int unsigned ACK_MODE    = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic reset_n,
  nios2_debug_slave_sysclk_gen2_if.slave bus
);

  localparam int unsigned NI = 2 ** IR_W;

  typedef enum logic [0:0] {StIdle, StPend} state_e;

  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic                   r_uir_last;
  logic                   r_udr_last;

  state_e                 r_state;
  logic [DATA_W-1:0]      r_jdo;
  logic [IR_W-1:0]        r_ir_q;
  logic [NI-1:0]          r_take_act;
  logic [NI-1:0]          r_take_noact;
  logic                   r_ovr;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_uir_p;
  logic                   w_udr_p;
  logic [NI-1:0]          w_onehot;
  logic                   w_act;
  logic                   w_pend;
  logic                   w_accept;
  logic                   w_retire;
  logic                   w_drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_uir_sync <= '0;
      r_udr_sync <= '0;
      r_uir_last <= 1'b0;
      r_udr_last <= 1'b0;
    end else begin
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
      r_uir_last <= r_uir_sync[SYNC_STAGES-1];
      r_udr_last <= r_udr_sync[SYNC_STAGES-1];
    end
  end

  // Rising edge only; a long-held strobe yields a single pulse.
  assign w_uir_p  = r_uir_sync[SYNC_STAGES-1] & ~r_uir_last;
  assign w_udr_p  = r_udr_sync[SYNC_STAGES-1] & ~r_udr_last;

  // Indexed by the pre-update ir_q so a coincident IR update does not redirect the DR.
  assign w_onehot = {{(NI-1){1'b0}}, 1'b1} << r_ir_q;
  assign w_act    = bus.sr[ACT_BIT];
  assign w_pend   = (ACK_MODE != 0) && (r_state == StPend);

  assign w_accept = w_udr_p & (~w_pend | bus.act_ack);
  assign w_retire = w_pend & bus.act_ack & ~w_udr_p;
  assign w_drop   = w_pend & w_udr_p & ~bus.act_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_jdo        <= '0;
      r_ir_q       <= '0;
      r_take_act   <= '0;
      r_take_noact <= '0;
      r_ovr        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (w_uir_p) begin
        r_ir_q <= bus.ir_in;
      end

      if (w_accept) begin
        r_jdo        <= bus.sr;
        r_cnt        <= r_cnt + CNT_W'(1);
        r_take_act   <= w_act ? w_onehot : '0;
        r_take_noact <= w_act ? '0 : w_onehot;
        if (ACK_MODE != 0) begin
          r_state <= StPend;
        end
      end else if ((ACK_MODE == 0) || w_retire) begin
        r_take_act   <= '0;
        r_take_noact <= '0;
        r_state      <= StIdle;
      end

      // Set is evaluated after clear so a coincident overrun wins.
      if (bus.ovr_clr) begin
        r_ovr <= 1'b0;
      end
      if (w_drop) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign bus.jdo            = r_jdo;
  assign bus.ir_q           = r_ir_q;
  assign bus.take_action    = r_take_act;
  assign bus.take_no_action = r_take_noact;
  assign bus.cmd_pending    = (r_state == StPend);
  assign bus.overrun        = r_ovr;
  assign bus.cmd_count      = r_cnt;

endmodule

// File: tb/tb_nios2_debug_slave_sysclk_gen2.sv
// Bench for the sysclk debug slave: one instance without and one with the ack
// handshake, driven by a directed sequence and checked against a capture scoreboard.
module tb_nios2_debug_slave_sysclk_gen2;

  localparam int unsigned DW = 38;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [DW-1:0] jdo;
    logic [3:0]    ta;
    logic [3:0]    tna;
    logic [CW-1:0] cnt;
  } rec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nios2_debug_slave_sysclk_gen2_if #(.DATA_W(DW), .IR_W(IW), .CNT_W(CW)) bus0 ();
  nios2_debug_slave_sysclk_gen2_if #(.DATA_W(DW), .IR_W(IW), .CNT_W(CW)) bus1 ();

  nios2_debug_slave_sysclk_gen2 #(
    .DATA_W(DW), .IR_W(IW), .SYNC_STAGES(2), .ACT_BIT(36), .ACK_MODE(0), .CNT_W(CW)
  ) dut0 (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus0)
  );

  nios2_debug_slave_sysclk_gen2 #(
    .DATA_W(DW), .IR_W(IW), .SYNC_STAGES(2), .ACT_BIT(36), .ACK_MODE(1), .CNT_W(CW)
  ) dut1 (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus1)
  );

  int total = 0;
  int bad = 0;
  rec_t q0[$];
  rec_t q1[$];
  logic [IW-1:0] m_ir[2];
  logic [CW-1:0] m_cnt[2];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(input logic [DW-1:0] v, input logic [IW-1:0] ir,
                              input logic [CW-1:0] cnt);
    logic [3:0] oh;
    oh = 4'b0001 << ir;
    mk.jdo = v;
    mk.ta  = v[36] ? oh : 4'b0000;
    mk.tna = v[36] ? 4'b0000 : oh;
    mk.cnt = cnt;
  endfunction

  task automatic snap(input int sel, output rec_t o);
    if (sel == 0) begin
      o.jdo = bus0.jdo; o.ta = bus0.take_action; o.tna = bus0.take_no_action;
      o.cnt = bus0.cmd_count;
    end else begin
      o.jdo = bus1.jdo; o.ta = bus1.take_action; o.tna = bus1.take_no_action;
      o.cnt = bus1.cmd_count;
    end
  endtask

  task automatic check_zero(input int sel, input string tag);
    rec_t o;
    snap(sel, o);
    check({tag, "_rec"}, o, '0);
    if (sel == 0) check({tag, "_misc"}, {bus0.ir_q, bus0.cmd_pending, bus0.overrun}, '0);
    else          check({tag, "_misc"}, {bus1.ir_q, bus1.cmd_pending, bus1.overrun}, '0);
  endtask

  task automatic set_ir(input int sel, input logic [IW-1:0] v);
    if (sel == 0) begin bus0.ir_in = v; bus0.vs_uir = 1'b1; end
    else          begin bus1.ir_in = v; bus1.vs_uir = 1'b1; end
    tick(4);
    bus0.vs_uir = 1'b0;
    bus1.vs_uir = 1'b0;
    tick(4);
    m_ir[sel] = v;
    check("ir_q", (sel == 0) ? bus0.ir_q : bus1.ir_q, v);
  endtask

  // Expects a fresh accepted command; predicts it and queues the prediction.
  task automatic push_dr(input int sel, input logic [DW-1:0] v);
    m_cnt[sel]++;
    if (sel == 0) begin
      q0.push_back(mk(v, m_ir[0], m_cnt[0]));
      bus0.sr = v; bus0.vs_udr = 1'b1;
    end else begin
      q1.push_back(mk(v, m_ir[1], m_cnt[1]));
      bus1.sr = v; bus1.vs_udr = 1'b1;
    end
  endtask

  task automatic pop_cmp(input int sel, input string tag);
    rec_t o, e;
    snap(sel, o);
    if (sel == 0) e = q0.pop_front();
    else          e = q1.pop_front();
    check(tag, o, e);
  endtask

  // Bounded wait for a strobe; latency is counted from the first sampling edge.
  task automatic expect_capture(input int sel, input string tag);
    rec_t o;
    int lat;
    logic hit;
    lat = 0;
    hit = 1'b0;
    for (int i = 1; i <= 12 && !hit; i++) begin
      tick(1);
      snap(sel, o);
      if ((o.ta | o.tna) != 4'b0000) begin
        hit = 1'b1;
        lat = i;
      end
    end
    check({tag, "_lat"}, lat, 3);
    pop_cmp(sel, {tag, "_rec"});
  endtask

  task automatic dr_full0(input logic [DW-1:0] v, input string tag);
    push_dr(0, v);
    expect_capture(0, tag);
    tick(1);
    check({tag, "_1clk"}, {bus0.take_action, bus0.take_no_action}, '0);
    tick(2);
    bus0.vs_udr = 1'b0;
    tick(4);
    check({tag, "_norepulse"}, {bus0.take_action, bus0.take_no_action}, '0);
  endtask

  task automatic udr_pulse(input int sel, input logic [DW-1:0] v, input int hold);
    if (sel == 0) begin bus0.sr = v; bus0.vs_udr = 1'b1; end
    else          begin bus1.sr = v; bus1.vs_udr = 1'b1; end
    tick(hold);
    bus0.vs_udr = 1'b0;
    bus1.vs_udr = 1'b0;
    tick(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t o, last;
    logic [DW-1:0] v;
    int n;
    bus0.vs_uir = 0; bus0.vs_udr = 0; bus0.ir_in = '0; bus0.sr = '0;
    bus0.act_ack = 0; bus0.ovr_clr = 0;
    bus1.vs_uir = 0; bus1.vs_udr = 0; bus1.ir_in = '0; bus1.sr = '0;
    bus1.act_ack = 0; bus1.ovr_clr = 0;
    m_ir = '{default: '0};
    m_cnt = '{default: '0};

    #1;
    check_zero(0, "rst0");
    check_zero(1, "rst1");
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Action and no-action captures, one-clk strobes
    set_ir(0, 2'b10);
    dr_full0(38'h3A_1234_5678, "t1");
    dr_full0(38'h2A_1234_5678, "t2");

    // Held strobe, dropped command with overrun, ack, overrun clear
    set_ir(1, 2'b01);
    push_dr(1, 38'h30_0000_BEEF);
    last = q1[0];
    expect_capture(1, "t3");
    tick(5);
    bus1.vs_udr = 1'b0;
    tick(15);
    snap(1, o);
    check("t3_held", o, last);
    check("t3_pend", bus1.cmd_pending, 1'b1);
    udr_pulse(1, 38'h1, 6);
    snap(1, o);
    check("t3_drop", o, last);
    check("t3_ovr", bus1.overrun, 1'b1);
    bus1.act_ack = 1'b1;
    tick(1);
    bus1.act_ack = 1'b0;
    check("t3_ack", {bus1.take_action, bus1.take_no_action, bus1.cmd_pending, bus1.overrun},
          {8'h00, 1'b0, 1'b1});
    check("t3_jdo_hold", bus1.jdo, last.jdo);
    bus1.ovr_clr = 1'b1;
    tick(1);
    bus1.ovr_clr = 1'b0;
    check("t3_ovr_clr", bus1.overrun, 1'b0);

    // Ack coinciding with a new update in PEND
    push_dr(1, 38'h10_0000_00AB);
    expect_capture(1, "t4a");
    tick(3);
    bus1.vs_udr = 1'b0;
    tick(4);
    push_dr(1, 38'h00_CAFE_F00D);
    tick(2);
    bus1.act_ack = 1'b1;
    tick(1);
    bus1.act_ack = 1'b0;
    pop_cmp(1, "t4_cap");
    check("t4_state", {bus1.cmd_pending, bus1.overrun}, 2'b10);
    tick(3);
    bus1.vs_udr = 1'b0;
    tick(4);
    bus1.act_ack = 1'b1;
    tick(1);
    bus1.act_ack = 1'b0;
    check("t4_idle", bus1.cmd_pending, 1'b0);

    // Coincident IR and DR updates, then counter wrap
    set_ir(0, 2'b01);
    push_dr(0, 38'h1F_0000_0001);
    bus0.ir_in = 2'b11;
    bus0.vs_uir = 1'b1;
    m_ir[0] = 2'b11;
    expect_capture(0, "t5");
    check("t5_irq", bus0.ir_q, 2'b11);
    tick(3);
    bus0.vs_uir = 1'b0;
    bus0.vs_udr = 1'b0;
    tick(4);
    n = 256 - int'(m_cnt[0]);
    v = '0;
    for (int i = 0; i < n; i++) begin
      v = DW'(i * 7 + 3);
      v[36] = i[0];
      udr_pulse(0, v, 4);
      m_cnt[0]++;
    end
    check("t5_wrap", bus0.cmd_count, m_cnt[0]);
    check("t5_wrap0", bus0.cmd_count, 8'd0);
    check("t5_jdo", bus0.jdo, v);

    // Asynchronous reset from PEND with overrun set
    push_dr(1, 38'h20_0000_0042);
    expect_capture(1, "t6a");
    tick(3);
    bus1.vs_udr = 1'b0;
    tick(4);
    udr_pulse(1, 38'h2, 6);
    check("t6_ovr", bus1.overrun, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    check_zero(1, "t6_rst1");
    check_zero(0, "t6_rst0");
    m_ir = '{default: '0};
    m_cnt = '{default: '0};
    tick(2);
    reset_n = 1'b1;
    tick(2);
    push_dr(1, 38'h00_0000_0777);
    expect_capture(1, "t6b");
    check("t6_cnt", bus1.cmd_count, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
